fact_core: RTL
==============

Name: fact_core

Overview:
- Iterative factorial engine that sits directly downstream of the factorial register front-end (operand/Go/status/result register block).
- Takes a one-cycle Go pulse and a registered operand n, and computes n! by repeated multiply-accumulate.
- Returns the result with a one-cycle Done strobe, or flags a one-cycle Err strobe when n! would overflow DATA_W.
- Exposes its state code for debug readback.

Parameters:
- N_W, 4, width of operand n.
- DATA_W, 32, width of result nf and accumulator.
- MAX_N, 12, largest n whose factorial fits in DATA_W (12! = 479001600 < 2^32; 13! overflows).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Go  in  1  start strobe, one cycle wide, sampled only in IDLE.
- n  in  N_W  operand, sampled on the edge where Go is accepted.
- nf  out  DATA_W  accumulator/result; valid while Done=1, held afterwards.
- Done  out  1  one-cycle strobe: nf holds n!.
- Err  out  1  one-cycle strobe: n > MAX_N, no result produced.
- CS  out  3  current state code.

Behaviour:
- Reset: Rst=0 asynchronously forces:
  - state IDLE (CS=3'd0)
  - nf=0, internal counter cnt=0, latched operand=0
  - Done=0, Err=0
  - Reset mid-computation abandons the operation; no Done or Err is emitted.
- State codes: IDLE=0, LOAD=1, MULT=2, DONE=3, ERR=4. Codes 5-7 are illegal and go to IDLE on the next edge with no strobe.
- IDLE:
  - Go=1 latches n into cnt and goes to LOAD.
  - Go=0 stays in IDLE.
  - nf holds its value.
- LOAD (one cycle):
  - cnt > MAX_N goes to ERR; nf is untouched.
  - Otherwise nf<=1 and go to MULT.
- MULT:
  - cnt <= 1 goes to DONE; nf is unchanged.
  - Otherwise nf <= (nf*cnt)[DATA_W-1:0], cnt <= cnt-1, stay in MULT.
  - The full product is DATA_W+N_W bits wide, truncated to DATA_W. Truncation never loses bits because n <= MAX_N is guaranteed.
- DONE (one cycle): Done=1, then IDLE.
- ERR (one cycle): Err=1, then IDLE.
- Done and Err are Moore outputs decoded from state. They are glitch-free, never both high, and exactly one cycle wide.
- Latency, with Go sampled at edge 0:
  - Done is high in cycle max(n,1)+2 (n=0 or 1 gives cycle 3; n=5 gives cycle 7; n=12 gives cycle 14).
  - Err is high in cycle 2.
- Go outside IDLE (LOAD/MULT/DONE/ERR) is ignored. n changes after acceptance are ignored.
- Go in the IDLE cycle immediately after DONE/ERR is accepted, so back-to-back operations are allowed.
- nf holds its final value after DONE until the next accepted non-error operation reaches LOAD. An Err operation leaves nf unchanged.
- CS always reflects the registered state; it is never a next-state value.

Test Plan:
- Reset release, Go=1 with n=5 at edge 0 -> CS walks 0,1,2x5,3,0; Done high only in cycle 7 with nf=120; Err stays 0; nf=120 held afterwards.
- n=0, then n=1 (separate Go pulses) -> each produces Done in cycle 3 with nf=1.
- n=12 -> Done in cycle 14, nf=32'h1C8CFC00 (479001600). Then n=13 -> Err high only in cycle 2, Done never asserts, nf remains 479001600, CS returns to 0 in cycle 3.
- Go=1 with n=6, then extra Go pulses with n=3 in cycles 2, 4 and DONE cycle -> single Done, nf=720, no second operation started.
- Go with n=10; drive Rst=0 asynchronously mid-cycle 5 -> CS=0, nf=0, Done=Err=0 immediately, with no strobe after release. A fresh Go with n=4 then yields nf=24.
- Back-to-back: Go n=3 and, in the cycle after its Done, Go n=15 -> Done nf=6, then Err two cycles after the second Go, nf stays 6.

Source files
------------

// File: rtl/fact_core_if.sv
// Handshake bundle between the factorial register front-end (master) and fact_core (slave).
// go/n carry the request; nf/done/err/cs carry the result and debug state back.
interface fact_core_if #(
  parameter int N_W    = 4,
  parameter int DATA_W = 32
);
  logic              go;
  logic [N_W-1:0]    n;
  logic [DATA_W-1:0] nf;
  logic              done;
  logic              err;
  logic [2:0]        cs;

  modport master (output go, output n, input nf, input done, input err, input cs);
  modport slave  (input go, input n, output nf, output done, output err, output cs);
endinterface

// File: rtl/fact_core.sv
// Iterative factorial engine: computes n! by repeated multiply, with Done/Err strobes.
// Operands above MAX_N are rejected with Err before any multiply, so nf never wraps.
module fact_core #(
  parameter int N_W    = 4,
  parameter int DATA_W = 32,
  parameter int MAX_N  = 12
) (
  input logic       clk,
  input logic       rst,
  fact_core_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MULT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [N_W-1:0]           cnt_r;
  logic [N_W-1:0]           cnt_next_s;
  logic [DATA_W-1:0]        nf_r;
  logic [DATA_W-1:0]        nf_next_s;
  logic                     done_r;
  logic                     err_r;
  logic [DATA_W+N_W-1:0]    prod_s;

  // Full-width product; the top N_W bits are always zero for n <= MAX_N.
  assign prod_s = {{N_W{1'b0}}, nf_r} * {{DATA_W{1'b0}}, cnt_r};

  // Next-state and datapath update for the factorial sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    nf_next_s    = nf_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.go) begin
          cnt_next_s   = bus.n;
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (int'(cnt_r) > MAX_N) begin
          state_next_s = ST_ERR;
        end else begin
          nf_next_s    = {{(DATA_W-1){1'b0}}, 1'b1};
          state_next_s = ST_MULT;
        end
      end
      ST_MULT: begin
        if (cnt_r <= {{(N_W-1){1'b0}}, 1'b1}) begin
          state_next_s = ST_DONE;
        end else begin
          nf_next_s    = prod_s[DATA_W-1:0];
          cnt_next_s   = cnt_r - {{(N_W-1){1'b0}}, 1'b1};
          state_next_s = ST_MULT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath and strobe registers; strobes follow the state they announce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {N_W{1'b0}};
      nf_r    <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      nf_r    <= nf_next_s;
      done_r  <= (state_next_s == ST_DONE);
      err_r   <= (state_next_s == ST_ERR);
    end
  end

  assign bus.nf   = nf_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.cs   = state_r;

endmodule
